// File: rtl/fbp_cfg_ctrl.sv
// Control/configuration block for the FBP accelerator: per-channel address
// handshakes, start sequencing, timed soft reset, run counter, irq and status.
module fbp_cfg_ctrl #(
  parameter int                DATA_W       = 32,
  parameter int                NUM_CH       = 2,
  parameter logic [DATA_W-1:0] DEFAULT_BASE = 32'h6000_0000,
  parameter int                CNT_W        = 24,
  parameter int                SRST_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     ctrl_wr,
  input  logic [DATA_W-1:0]        ctrl_data,
  input  logic [NUM_CH-1:0]        addr_wr,
  input  logic [NUM_CH*DATA_W-1:0] addr_data,
  output logic [NUM_CH-1:0]        addr_valid,
  input  logic [NUM_CH-1:0]        addr_ready,
  output logic [NUM_CH*DATA_W-1:0] addr_out,
  output logic                     start_fbp,
  input  logic                     done_fbp,
  output logic                     soft_rstn,
  output logic                     irq,
  output logic [DATA_W-1:0]        status
);

  localparam int TMR_W = $clog2(SRST_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SRST_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, SRST} state_t;

  state_t                     state_reg;
  logic [NUM_CH*DATA_W-1:0]   addr_reg;
  logic [NUM_CH*DATA_W-1:0]   addr_next;
  logic [NUM_CH-1:0]          addr_valid_reg;
  logic [NUM_CH-1:0]          addr_valid_next;
  logic                       start_fbp_reg;
  logic                       soft_rstn_reg;
  logic [TMR_W-1:0]           timer_reg;
  logic [CNT_W-1:0]           count_reg;
  logic [CNT_W-1:0]           final_reg;
  logic                       ovf_reg;
  logic                       err_reg;
  logic                       irq_reg;
  logic                       irq_en_reg;
  logic [DATA_W-1:0]          status_reg;
  logic [DATA_W-1:0]          status_next;

  logic start_req;
  logic srst_req;
  logic clr_req;
  logic pending;
  logic clear_valid;
  logic launch;
  logic done_ev;
  logic err_set;
  logic irq_set;
  logic cnt_sat;
  logic [CNT_W-1:0] count_inc;
  logic unused_ctrl_bits;

  assign start_req   = ctrl_wr & ctrl_data[0] & ~ctrl_data[DATA_W-1];
  assign srst_req    = ctrl_wr & ctrl_data[DATA_W-1];
  assign clr_req     = ctrl_wr & ctrl_data[2];
  assign pending     = (|addr_valid_reg) | (|addr_wr);
  assign clear_valid = srst_req | (state_reg == SRST);
  assign unused_ctrl_bits = ^ctrl_data[DATA_W-2:3];

  // A soft-reset write overrides every FSM decision made in the same cycle.
  assign launch  = ~srst_req & ~pending &
                   (((state_reg == IDLE) & start_req) | (state_reg == ARM));
  assign done_ev = done_fbp & (state_reg == RUN) & ~srst_req;
  assign err_set = start_req & ((state_reg == ARM) | (state_reg == RUN));
  assign irq_set = done_ev & irq_en_reg;

  assign cnt_sat   = &count_reg;
  assign count_inc = cnt_sat ? count_reg : count_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign addr_next[gi*DATA_W +: DATA_W] = addr_wr[gi] ?
          addr_data[gi*DATA_W +: DATA_W] : addr_reg[gi*DATA_W +: DATA_W];
      // A write in the handshake cycle is a fresh transfer, so it keeps valid high.
      assign addr_valid_next[gi] = clear_valid ? 1'b0 :
                                   addr_wr[gi] ? 1'b1 :
                                   (addr_valid_reg[gi] & addr_ready[gi]) ? 1'b0 :
                                   addr_valid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_reg       <= {NUM_CH{DEFAULT_BASE}};
      addr_valid_reg <= '0;
    end else begin
      addr_reg       <= addr_next;
      addr_valid_reg <= addr_valid_next;
    end
  end

  always_comb begin
    status_next = '0;
    status_next[0] = (state_reg == RUN);
    status_next[1] = irq_reg;
    status_next[2] = err_reg;
    status_next[3] = ovf_reg;
    status_next[CNT_W+3:4] = (state_reg == RUN) ? count_reg : final_reg;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= IDLE;
      start_fbp_reg <= 1'b0;
      soft_rstn_reg <= 1'b1;
      timer_reg     <= '0;
      count_reg     <= '0;
      final_reg     <= '0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
      irq_reg       <= 1'b0;
      irq_en_reg    <= 1'b0;
      status_reg    <= '0;
    end else begin
      start_fbp_reg <= 1'b0;
      status_reg    <= status_next;
      if (ctrl_wr)
        irq_en_reg <= ctrl_data[1];
      // Sticky flags: a set event in the same cycle beats the W1C clear.
      if (err_set)
        err_reg <= 1'b1;
      else if (clr_req)
        err_reg <= 1'b0;
      if (irq_set)
        irq_reg <= 1'b1;
      else if (clr_req)
        irq_reg <= 1'b0;

      if (srst_req) begin
        state_reg     <= SRST;
        timer_reg     <= TMR_LOAD;
        soft_rstn_reg <= 1'b0;
        count_reg     <= '0;
        final_reg     <= '0;
        ovf_reg       <= 1'b0;
      end else if (launch) begin
        state_reg     <= RUN;
        start_fbp_reg <= 1'b1;
        count_reg     <= '0;
        ovf_reg       <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_req)
              state_reg <= ARM;
          end
          ARM: begin
            state_reg <= ARM;
          end
          RUN: begin
            count_reg <= count_inc;
            if (cnt_sat)
              ovf_reg <= 1'b1;
            if (done_fbp) begin
              state_reg <= IDLE;
              final_reg <= count_inc;
            end
          end
          SRST: begin
            if (timer_reg == '0) begin
              state_reg     <= IDLE;
              soft_rstn_reg <= 1'b1;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign addr_out   = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign start_fbp  = start_fbp_reg;
  assign soft_rstn  = soft_rstn_reg;
  assign irq        = irq_reg;
  assign status     = status_reg;

endmodule
